cam_pattern_gen: RTL

Synthetic OV7670-style DVP source: emits vsync/href/8-bit data in RGB444 (2 bytes per pixel) with the camera's frame timing, driven from one system clock. It is the transmitter end of the camera capture interface: it feeds `cam_top`'s `i_cam_vsync`, `i_cam_href` and `i_cam_data`, with `i_clk` doubling as `i_cam_pclk`. It serves as a deterministic stand-in for the sensor during board bring-up and pipeline verification.

---
 rtl/cam_pattern_gen.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/cam_pattern_gen.sv
// Synthetic OV7670-style DVP source: registered vsync/href/byte stream in RGB444
// (two bytes per pixel) with camera-like frame timing, one byte per i_clk cycle.
module cam_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10,
    parameter int CHK_BIT  = 5
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_enable,
    input  logic [1:0]  i_pattern,
    input  logic [11:0] i_solid,
    output logic        o_vsync,
    output logic        o_href,
    output logic [7:0]  o_data,
    output logic        o_sof,
    output logic [15:0] o_frame_cnt,
    output logic        o_busy
);

    localparam logic [31:0] LINE_CYC = 32'(2 * H_ACTIVE + H_BLANK);
    localparam logic [31:0] D_VSYNC  = 32'(V_SYNC) * LINE_CYC;
    localparam logic [31:0] D_VBACK  = 32'(V_BACK) * LINE_CYC;
    localparam logic [31:0] D_VFRONT = 32'(V_FRONT) * LINE_CYC;
    localparam logic [31:0] D_ACT    = 32'(2 * H_ACTIVE);
    localparam logic [31:0] D_BLANK  = 32'(H_BLANK);
    localparam logic [10:0] Y_LAST   = 11'(V_ACTIVE - 1);
    localparam logic [10:0] BAR_W    = 11'((H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_VSYNC      = 3'd1;
    localparam logic [2:0] ST_VBACK      = 3'd2;
    localparam logic [2:0] ST_LINE_ACT   = 3'd3;
    localparam logic [2:0] ST_LINE_BLANK = 3'd4;
    localparam logic [2:0] ST_VFRONT     = 3'd5;
    localparam logic [2:0] ST_END        = 3'd7;

    // Successor of each phase with zero-length phases folded away; ST_END marks frame end.
    localparam logic [2:0] FIRST_LINE_ST  = (H_ACTIVE > 0) ? ST_LINE_ACT : ST_LINE_BLANK;
    localparam logic [2:0] AFTER_LINES_ST = (V_FRONT > 0) ? ST_VFRONT : ST_END;
    localparam logic [2:0] AFTER_BACK_ST  = (V_ACTIVE > 0) ? FIRST_LINE_ST : AFTER_LINES_ST;
    localparam logic [2:0] AFTER_SYNC_ST  = (V_BACK > 0) ? ST_VBACK : AFTER_BACK_ST;
    localparam logic [2:0] FRAME_ST       = (V_SYNC > 0) ? ST_VSYNC : AFTER_SYNC_ST;
    localparam logic [2:0] FRAME_ST_R     = (FRAME_ST == ST_END) ? ST_IDLE : FRAME_ST;

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [10:0] y_q, y_d;
    logic [1:0]  pat_q, pat_d;
    logic [11:0] solid_q, solid_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  data_q, data_d;
    logic        sof_q, sof_d;
    logic        busy_q, busy_d;
    logic        start;

    logic [10:0] x_w;
    logic [10:0] bar_w;
    logic [11:0] colour_w;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        y_d     = y_q;
        pat_d   = pat_q;
        solid_d = solid_q;
        fcnt_d  = fcnt_q;
        sof_d   = 1'b0;
        start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 32'd0;
                start = i_enable;
            end
            ST_VSYNC: begin
                if (cnt_q == D_VSYNC - 32'd1) begin
                    state_d = AFTER_SYNC_ST;
                    cnt_d   = 32'd0;
                end
            end
            ST_VBACK: begin
                if (cnt_q == D_VBACK - 32'd1) begin
                    state_d = AFTER_BACK_ST;
                    cnt_d   = 32'd0;
                end
            end
            ST_LINE_ACT: begin
                if (cnt_q == D_ACT - 32'd1) begin
                    state_d = ST_LINE_BLANK;
                    cnt_d   = 32'd0;
                end
            end
            ST_LINE_BLANK: begin
                if (cnt_q == D_BLANK - 32'd1) begin
                    cnt_d = 32'd0;
                    if (y_q == Y_LAST) begin
                        state_d = AFTER_LINES_ST;
                    end else begin
                        state_d = FIRST_LINE_ST;
                        y_d     = y_q + 11'd1;
                    end
                end
            end
            ST_VFRONT: begin
                if (cnt_q == D_VFRONT - 32'd1) begin
                    state_d = ST_END;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A finished frame either restarts immediately or parks in IDLE.
        if (state_d == ST_END) begin
            if (i_enable) begin
                start = 1'b1;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = 32'd0;
            end
        end

        if (start) begin
            state_d = FRAME_ST_R;
            cnt_d   = 32'd0;
            y_d     = 11'd0;
            pat_d   = i_pattern;
            solid_d = i_solid;
            sof_d   = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
        end
    end

    always_comb begin
        x_w      = cnt_d[11:1];
        bar_w    = x_w / BAR_W;
        colour_w = 12'h000;
        case (pat_d)
            2'd0: begin
                case (bar_w)
                    11'd0:   colour_w = 12'hFFF;
                    11'd1:   colour_w = 12'hFF0;
                    11'd2:   colour_w = 12'h0FF;
                    11'd3:   colour_w = 12'h0F0;
                    11'd4:   colour_w = 12'hF0F;
                    11'd5:   colour_w = 12'hF00;
                    11'd6:   colour_w = 12'h00F;
                    default: colour_w = 12'h000;
                endcase
            end
            2'd1:    colour_w = {3{x_w[7:4]}};
            2'd2:    colour_w = (x_w[CHK_BIT] ^ y_d[CHK_BIT]) ? 12'hFFF : 12'h000;
            default: colour_w = solid_d;
        endcase

        vsync_d = (state_d == ST_VSYNC);
        href_d  = (state_d == ST_LINE_ACT);
        busy_d  = (state_d != ST_IDLE);
        data_d  = 8'h00;
        if (href_d) begin
            data_d = cnt_d[0] ? colour_w[7:0] : {4'h0, colour_w[11:8]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 32'd0;
            y_q     <= 11'd0;
            pat_q   <= 2'd0;
            solid_q <= 12'h000;
            fcnt_q  <= 16'd0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            sof_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
            fcnt_q  <= fcnt_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            sof_q   <= sof_d;
            busy_q  <= busy_d;
        end
    end

    assign o_vsync     = vsync_q;
    assign o_href      = href_q;
    assign o_data      = data_q;
    assign o_sof       = sof_q;
    assign o_frame_cnt = fcnt_q;
    assign o_busy      = busy_q;

endmodule
